// File: rtl/quant_pkg.sv
// Shared constants, default JPEG luminance quantizer tables and the rounding helper
// for block_quantizer.
package quant_pkg;

  localparam int unsigned COEF_W  = 32;
  localparam int unsigned RECIP_W = 17;
  localparam int unsigned FRAC    = 16;
  localparam int unsigned PROD_W  = COEF_W + RECIP_W + 1;

  // JPEG luminance quantizer, row-major [r*8+c]
  localparam int unsigned Q_TAB [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  // round(65536 / Q_TAB[i])
  localparam int unsigned RECIP_TAB [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

  // Round half away from zero, then drop the fraction bits.
  function automatic logic [COEF_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic [PROD_W-1:0] mag;
    logic [PROD_W-1:0] rnd;
    mag = p[PROD_W-1] ? -p : p;
    rnd = (mag + (PROD_W'(1) << (FRAC - 1))) >> FRAC;
    if (p[PROD_W-1]) begin
      rnd = -rnd;
    end
    return rnd[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/block_quantizer_if.sv
// Valid/ready packet channel used on both sides of block_quantizer.
interface block_quantizer_if #(
  parameter int unsigned width = 280
);
  logic [width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/quant_lane.sv
// One coefficient lane: signed multiply by reciprocal, then round/shift; both stages
// advance only on en.
module quant_lane
  import quant_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [COEF_W-1:0]  coef,
  input  logic [RECIP_W-1:0] recip,
  output logic [COEF_W-1:0]  q
);

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic [COEF_W-1:0]        q_q;

  assign prod_d = PROD_W'($signed(coef)) * PROD_W'($signed({1'b0, recip}));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q <= '0;
      q_q    <= '0;
    end else if (en) begin
      prod_q <= prod_d;
      q_q    <= round_shift(prod_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/block_quantizer.sv
// Quantizes 8-coefficient DCT row packets by a per-position reciprocal table.
// Define QUANT_TABLE_WR_EN to make the table a writable register file.
module block_quantizer
  import quant_pkg::*;
#(
  parameter int unsigned x_size      = 8,
  parameter int unsigned y_size      = 8,
  parameter int unsigned pck_num     = 8,
  parameter int unsigned data_width  = 256,
  parameter int unsigned total_width = data_width + pck_num + y_size + x_size
) (
  input  logic                clk,
  input  logic                rstn,
  block_quantizer_if.slave    in_bus,
  block_quantizer_if.master   out_bus,
`ifdef QUANT_TABLE_WR_EN
  input  logic                tbl_we,
  input  logic [5:0]          tbl_addr,
  input  logic [RECIP_W-1:0]  tbl_data,
`endif
  output logic                seq_err
);

  localparam int unsigned HdrW   = x_size + y_size + pck_num;
  localparam int unsigned RowLsb = x_size + y_size;

  logic                   adv, accept;
  logic [2:0]             in_row, s0_row;
  logic                   s0_valid_q, s1_valid_q, out_valid_q;
  logic [total_width-1:0] s0_data_q, o_data;
  logic [HdrW-1:0]        s1_hdr_q, out_hdr_q;
  logic [2:0]             exp_row_q;
  logic                   seq_err_q;
  logic [COEF_W-1:0]      out_coef [8];

  // Single global stall: every stage, bubbles included, moves together.
  assign adv          = ~out_valid_q | out_bus.ready;
  assign in_bus.ready = adv;
  assign accept       = in_bus.valid & adv;
  assign in_row       = in_bus.data[RowLsb +: 3];
  assign s0_row       = s0_data_q[RowLsb +: 3];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s0_data_q   <= '0;
      s1_hdr_q    <= '0;
      out_hdr_q   <= '0;
    end else if (adv) begin
      s0_valid_q  <= in_bus.valid;
      s1_valid_q  <= s0_valid_q;
      out_valid_q <= s1_valid_q;
      s0_data_q   <= in_bus.data;
      s1_hdr_q    <= s0_data_q[HdrW-1:0];
      out_hdr_q   <= s1_hdr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_row_q <= 3'd0;
      seq_err_q <= 1'b0;
    end else if (accept) begin
      if (in_row != exp_row_q) begin
        seq_err_q <= 1'b1;
        exp_row_q <= in_row + 3'd1;
      end else begin
        exp_row_q <= exp_row_q + 3'd1;
      end
    end
  end

`ifdef QUANT_TABLE_WR_EN
  logic [RECIP_W-1:0] tbl_q [64];

  // Read is combinational from S0, so a same-edge write is seen only by later rows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        tbl_q[i] <= RECIP_W'(RECIP_TAB[i]);
      end
    end else if (tbl_we) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end
`endif

  for (genvar c = 0; c < 8; c++) begin : g_lane
    logic [RECIP_W-1:0] recip;
`ifdef QUANT_TABLE_WR_EN
    assign recip = tbl_q[{s0_row, 3'(c)}];
`else
    assign recip = RECIP_W'(RECIP_TAB[{s0_row, 3'(c)}]);
`endif
    quant_lane u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .en    (adv),
      .coef  (s0_data_q[HdrW + data_width - 1 - c * COEF_W -: COEF_W]),
      .recip (recip),
      .q     (out_coef[c])
    );
  end

  always_comb begin
    o_data            = '0;
    o_data[HdrW-1:0]  = out_hdr_q;
    for (int c = 0; c < 8; c++) begin
      o_data[HdrW + data_width - 1 - c * COEF_W -: COEF_W] = out_coef[c];
    end
  end

  assign out_bus.data  = o_data;
  assign out_bus.valid = out_valid_q;
  assign seq_err       = seq_err_q;

endmodule
